// File: rtl/pcm_pkg.sv
// Shared definitions for the PCM frame scheduler: default sample and slot
// widths, the FSM state encoding and the stereo pair carried through the
// holding register and the shifters.
package pcm_pkg;

   localparam int PCM_SAMPLE_W = 24;
   localparam int PCM_SLOT_W   = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOPPING
   } state_t;

   // The pair is sized by the package default sample width.
   typedef struct packed {
      logic [PCM_SAMPLE_W-1:0] left;
      logic [PCM_SAMPLE_W-1:0] right;
   } pair_t;

endpackage

// File: rtl/pcm_clk_div.sv
// Bit/word clock divider for the PCM frame scheduler.
// Ports:
//   scki, rst      - system clock, async active-low reset
//   run            - counters advance while high, are held at 0 while low
//   bck, lrck      - registered bit clock and word clock
//   pos_nxt        - slot position of the coming cycle
//   lr_nxt         - coming cycle lies in the right slot
//   slot_start_nxt - coming cycle is the first cycle of a slot
//   frame_wrap     - this cycle is the last cycle of a frame
module pcm_clk_div
   import pcm_pkg::*;
#(
   parameter int SLOT_W       = PCM_SLOT_W,
   parameter int SCKI_PER_BCK = 8,
   localparam int DIV_W       = $clog2(SCKI_PER_BCK),
   localparam int BIT_W       = $clog2(2 * SLOT_W),
   localparam int POS_W       = $clog2(SLOT_W)
) (
   input  logic             scki,
   input  logic             rst,
   input  logic             run,
   output logic             bck,
   output logic             lrck,
   output logic [POS_W-1:0] pos_nxt,
   output logic             lr_nxt,
   output logic             slot_start_nxt,
   output logic             frame_wrap
);

   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic [BIT_W-1:0] bit_cnt, bit_nxt;
   logic             div_wrap;

   // NOTE: every signal written here gets a default first, so no latches.
   always_comb begin
      div_nxt    = '0;
      bit_nxt    = '0;
      div_wrap   = run && (div_cnt == DIV_W'(SCKI_PER_BCK - 1));
      frame_wrap = div_wrap && (bit_cnt == BIT_W'(2 * SLOT_W - 1));
      if (run) begin
         div_nxt = div_wrap ? '0 : div_cnt + DIV_W'(1);
         if (frame_wrap)
            bit_nxt = '0;
         else if (div_wrap)
            bit_nxt = bit_cnt + BIT_W'(1);
         else
            bit_nxt = bit_cnt;
      end
      lr_nxt         = (bit_nxt >= BIT_W'(SLOT_W));
      pos_nxt        = lr_nxt ? POS_W'(bit_nxt - BIT_W'(SLOT_W)) : POS_W'(bit_nxt);
      slot_start_nxt = run && (div_nxt == '0) && (pos_nxt == '0);
   end

   // bck/lrck are registered from the next-count values so they stay
   // glitch-free yet line up exactly with div_cnt/bit_cnt.
   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge scki or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         bck     <= 1'b0;
         lrck    <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         bit_cnt <= bit_nxt;
         bck     <= (div_nxt >= DIV_W'(SCKI_PER_BCK / 2));
         lrck    <= lr_nxt;
      end
   end

endmodule

// File: rtl/pcm_frame_sched.sv
// Frame scheduler for the serial PCM DAC path: accepts stereo pairs over
// valid/ready, keeps one pair in reserve and serializes it I2S-style.
// Ports:
//   scki, rst              - system clock, async active-low reset
//   en                     - run request, stop/start at frame boundaries
//   s_valid/s_left/s_right - upstream stereo pair, s_ready back-pressure
//   underrun_clr           - clears the sticky underrun flag
//   lrck, bck, adata       - serial PCM outputs
//   data_parallel          - sample of the slot currently being sent
//   frame_start            - pulse on the first cycle of every frame
//   underrun               - sticky: a frame started with no pair available
module pcm_frame_sched
   import pcm_pkg::*;
#(
   parameter int SAMPLE_W     = PCM_SAMPLE_W,
   parameter int SLOT_W       = PCM_SLOT_W,
   parameter int SCKI_PER_BCK = 8
) (
   input  logic                scki,
   input  logic                rst,
   input  logic                en,
   input  logic                s_valid,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic                s_ready,
   input  logic                underrun_clr,
   output logic                lrck,
   output logic                bck,
   output logic                adata,
   output logic [SAMPLE_W-1:0] data_parallel,
   output logic                frame_start,
   output logic                underrun
);

   localparam int POS_W = $clog2(SLOT_W);

   state_t           state, state_nxt;
   pair_t            hold, frame_pair, pair_nxt, in_pair;
   logic             hold_full;
   logic             live;
   logic             transfer;
   logic             run;
   logic             fs_nxt;
   logic             ur_set;
   logic             adata_nxt;
   logic [POS_W-1:0] pos_nxt, bit_idx;
   logic             lr_nxt, slot_start_nxt, frame_wrap;

   assign in_pair  = '{left: s_left, right: s_right};
   assign s_ready  = live && !hold_full;
   assign transfer = s_valid && s_ready;
   assign run      = (state != ST_IDLE);

   pcm_clk_div #(
      .SLOT_W       (SLOT_W),
      .SCKI_PER_BCK (SCKI_PER_BCK)
   ) u_clk_div (
      .scki           (scki),
      .rst            (rst),
      .run            (run),
      .bck            (bck),
      .lrck           (lrck),
      .pos_nxt        (pos_nxt),
      .lr_nxt         (lr_nxt),
      .slot_start_nxt (slot_start_nxt),
      .frame_wrap     (frame_wrap)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (en) state_nxt = ST_RUN;
         ST_RUN:      if (!en) state_nxt = frame_wrap ? ST_IDLE : ST_STOPPING;
         ST_STOPPING: if (en) state_nxt = ST_RUN;
                      else if (frame_wrap) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase

      // A frame begins either from IDLE or on a wrap we continue through.
      fs_nxt = (state_nxt == ST_RUN) && ((state == ST_IDLE) || frame_wrap);

      // The pair is picked during the frame_start cycle; slot position 0
      // lasts a whole bck period, so the shifters are ready before the MSB.
      pair_nxt = frame_pair;
      ur_set   = 1'b0;
      if (frame_start) begin
         if (hold_full) begin
            pair_nxt = hold;
         end else if (transfer) begin
            pair_nxt = in_pair;
         end else begin
            pair_nxt = '0;
            ur_set   = 1'b1;
         end
      end

      // MSB sits at slot position 1; positions 0 and past the sample are 0.
      bit_idx   = POS_W'(SAMPLE_W) - pos_nxt;
      adata_nxt = 1'b0;
      if ((pos_nxt != '0) && (pos_nxt <= POS_W'(SAMPLE_W)))
         adata_nxt = lr_nxt ? frame_pair.right[bit_idx] : frame_pair.left[bit_idx];
   end

   // NOTE: the holding and shift registers are reset as well, so a reset
   // mid-frame discards any pending pair and every output reads 0.
   always_ff @(posedge scki or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         live          <= 1'b0;
         hold          <= '0;
         hold_full     <= 1'b0;
         frame_pair    <= '0;
         frame_start   <= 1'b0;
         adata         <= 1'b0;
         data_parallel <= '0;
         underrun      <= 1'b0;
      end else begin
         state       <= state_nxt;
         live        <= 1'b1;
         frame_pair  <= pair_nxt;
         frame_start <= fs_nxt;
         adata       <= adata_nxt;

         // A bypass at frame start leaves the holding register empty.
         if (frame_start && hold_full)
            hold_full <= 1'b0;
         else if (transfer && !frame_start) begin
            hold      <= in_pair;
            hold_full <= 1'b1;
         end

         if (state_nxt == ST_IDLE)
            data_parallel <= '0;
         else if (frame_start)
            data_parallel <= pair_nxt.left;
         else if (slot_start_nxt && lr_nxt)
            data_parallel <= frame_pair.right;

         // A new underrun outranks a simultaneous clear.
         if (ur_set)
            underrun <= 1'b1;
         else if (underrun_clr)
            underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pcm_frame_sched.sv
// Directed bench for pcm_frame_sched with SCKI_PER_BCK=4, SLOT_W=32,
// SAMPLE_W=24: a frame is 256 scki cycles, slot position p = (c/4) mod 32.
// Inputs are driven and outputs sampled on the falling scki edge.
module tb_pcm_frame_sched;

   logic        scki = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        s_valid = 1'b0;
   logic [23:0] s_left = '0;
   logic [23:0] s_right = '0;
   logic        underrun_clr = 1'b0;
   logic        s_ready, lrck, bck, adata, frame_start, underrun;
   logic [23:0] data_parallel;

   pcm_frame_sched #(
      .SAMPLE_W     (24),
      .SLOT_W       (32),
      .SCKI_PER_BCK (4)
   ) dut (
      .scki          (scki),
      .rst           (rst),
      .en            (en),
      .s_valid       (s_valid),
      .s_left        (s_left),
      .s_right       (s_right),
      .s_ready       (s_ready),
      .underrun_clr  (underrun_clr),
      .lrck          (lrck),
      .bck           (bck),
      .adata         (adata),
      .data_parallel (data_parallel),
      .frame_start   (frame_start),
      .underrun      (underrun)
   );

   always #5 scki = ~scki;

   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   typedef struct {
      logic [23:0] l, r, dp_l, dp_r;
      int          lr_err, bck_err, pad_err, fs_err;
      logic        ur1, ur_pre, ur_post, ur_end, rdy_mid, rdy_end;
   } frame_res_t;

   // Runs one frame starting at the falling edge of its frame_start cycle
   // (c = 0) and ends at the falling edge of c = 255. Optional events:
   // two pushes, an underrun clear and dropping en, each at a cycle index.
   task automatic run_frame(input int push_a, input logic [23:0] la, input logic [23:0] ra,
                            input int push_b, input logic [23:0] lb, input logic [23:0] rb,
                            input int clr_at, input int stop_at, output frame_res_t res);
      res.l = '0; res.r = '0; res.dp_l = '0; res.dp_r = '0;
      res.lr_err = 0; res.bck_err = 0; res.pad_err = 0; res.fs_err = 0;
      res.ur1 = 1'b0; res.ur_pre = 1'b0; res.ur_post = 1'b0; res.ur_end = 1'b0;
      res.rdy_mid = 1'b0; res.rdy_end = 1'b0;
      for (int c = 0; c < 256; c++) begin
         int   p;
         logic slot_r;
         if (c > 0) @(negedge scki);
         p      = (c / 4) % 32;
         slot_r = (c >= 128);
         if (frame_start !== (c == 0)) res.fs_err++;
         if (lrck !== slot_r) res.lr_err++;
         if (bck !== ((c % 4) >= 2)) res.bck_err++;
         if ((c % 4) == 2) begin
            if (p >= 1 && p <= 24) begin
               if (slot_r) res.r = {res.r[22:0], adata};
               else        res.l = {res.l[22:0], adata};
            end else if (adata !== 1'b0) begin
               res.pad_err++;
            end
         end
         if (c == 64)  res.dp_l = data_parallel;
         if (c == 192) res.dp_r = data_parallel;
         if (c == 1)   res.ur1 = underrun;
         if (c == 10)  res.rdy_mid = s_ready;
         if (c == 255) begin
            res.ur_end  = underrun;
            res.rdy_end = s_ready;
         end
         if (c == clr_at + 1) begin
            res.ur_post  = underrun;
            underrun_clr = 1'b0;
         end
         if (c == clr_at) begin
            res.ur_pre   = underrun;
            underrun_clr = 1'b1;
         end
         if (c == push_a + 1 || c == push_b + 1) s_valid = 1'b0;
         if (c == push_a) begin
            s_valid = 1'b1; s_left = la; s_right = ra;
         end
         if (c == push_b) begin
            s_valid = 1'b1; s_left = lb; s_right = rb;
         end
         if (c == stop_at) en = 1'b0;
      end
   endtask

   task automatic check_frame(input string name, input frame_res_t res,
                              input logic [23:0] exp_l, input logic [23:0] exp_r);
      check({name, "_left_bits"}, res.l, exp_l);
      check({name, "_right_bits"}, res.r, exp_r);
      check({name, "_dp_left"}, res.dp_l, exp_l);
      check({name, "_dp_right"}, res.dp_r, exp_r);
      check({name, "_lrck_errs"}, res.lr_err, 0);
      check({name, "_bck_errs"}, res.bck_err, 0);
      check({name, "_pad_errs"}, res.pad_err, 0);
      check({name, "_fs_errs"}, res.fs_err, 0);
   endtask

   initial begin
      frame_res_t res;
      int         bad;

      // Reset: everything low while held, s_ready one edge after release.
      repeat (3) begin
         @(negedge scki);
         check("rst_outputs", {lrck, bck, adata, frame_start, s_ready, underrun, data_parallel}, 0);
      end
      rst = 1'b1;
      #1 check("rdy_at_release", s_ready, 0);
      @(negedge scki);
      check("rdy_after_release", s_ready, 1);
      repeat (5) @(negedge scki);
      check("idle_clocks", {lrck, bck, frame_start}, 0);

      // Frame 1: pair placed in holding, then started.
      s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h3C3C3C;
      @(negedge scki);
      s_valid = 1'b0; en = 1'b1;
      check("rdy_pair_held", s_ready, 0);
      @(negedge scki);
      check("fs_after_en", frame_start, 1);
      run_frame(-1, '0, '0, -1, '0, '0, -1, -1, res);
      check_frame("f1", res, 24'hA5A5A5, 24'h3C3C3C);
      check("f1_no_underrun", res.ur_end, 0);

      // Frame 2: nothing supplied -> zeros and sticky underrun, then clear.
      @(negedge scki);
      run_frame(-1, '0, '0, -1, '0, '0, 100, -1, res);
      check_frame("f2", res, 24'h000000, 24'h000000);
      check("f2_underrun_set", res.ur1, 1);
      check("f2_ur_before_clr", res.ur_pre, 1);
      check("f2_ur_after_clr", res.ur_post, 0);

      // Frame 3: bypass on the frame_start cycle, then reserve a pair.
      @(negedge scki);
      run_frame(0, 24'h000001, 24'h800000, 20, 24'h123456, 24'h654321, -1, -1, res);
      check_frame("f3", res, 24'h000001, 24'h800000);
      check("f3_no_underrun_start", res.ur1, 0);
      check("f3_no_underrun_end", res.ur_end, 0);
      check("f3_ready_after_bypass", res.rdy_mid, 1);

      // Frame 4: reserve another pair, drop en at bit_cnt 10.
      @(negedge scki);
      run_frame(20, 24'hABCDEF, 24'hFEDCBA, -1, '0, '0, -1, 40, res);
      check_frame("f4", res, 24'h123456, 24'h654321);
      check("f4_pair_retained", res.rdy_end, 0);
      check("f4_no_underrun", res.ur_end, 0);
      @(negedge scki);
      check("stop_idle_outputs", {lrck, bck, adata, frame_start}, 0);
      check("stop_ready", s_ready, 0);
      bad = 0;
      repeat (20) begin
         @(negedge scki);
         if ((frame_start | lrck | bck | adata) !== 1'b0) bad++;
      end
      check("idle_quiet", bad, 0);

      // Frame 5: restart sends the retained pair; reserve one more.
      en = 1'b1;
      @(negedge scki);
      run_frame(20, 24'h0F0F0F, 24'h00FF00, -1, '0, '0, -1, -1, res);
      check_frame("f5", res, 24'hABCDEF, 24'hFEDCBA);
      check("f5_no_underrun", res.ur_end, 0);

      // Frame 6: reserve a pair, then async reset at bit_cnt 40 (c = 160).
      repeat (21) @(negedge scki);
      s_valid = 1'b1; s_left = 24'h777777; s_right = 24'h111111;
      @(negedge scki);
      s_valid = 1'b0;
      check("f6_pair_held", s_ready, 0);
      repeat (139) @(negedge scki);
      check("f6_lrck_pre_rst", lrck, 1);
      check("f6_dp_pre_rst", data_parallel, 24'h00FF00);
      #2 rst = 1'b0; en = 1'b0;
      #1 check("async_rst_outputs", {lrck, bck, adata, frame_start, s_ready, underrun, data_parallel}, 0);
      repeat (2) @(negedge scki);
      rst = 1'b1;
      @(negedge scki);
      check("rst2_holding_empty", s_ready, 1);
      check("rst2_underrun", underrun, 0);
      en = 1'b1;
      @(negedge scki);
      check("rst2_fs", frame_start, 1);
      @(negedge scki);
      check("rst2_pair_discarded", underrun, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
